fsab_credit_issuer: RTL and testbench
=====================================

FSAB_CREDIT_ISSUER -- requirements
Module: fsab_credit_issuer

Interface
REQ-001 The block SHALL have parameter INITIAL_CREDITS, default 4, meaning request slots in the downstream arbiter FIFO.
REQ-002 The block SHALL have parameter LEN_MAX, default 8, meaning the maximum beats per write.
REQ-003 The block SHALL have parameter WRITE_MODE, default 1'b1, meaning the mode encoding for a write; 1'b0 means read.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have client request ports: req_valid (in, 1); req_ready (out, 1); req_mode (in, 1); req_did (in, 4); req_subdid (in, 4); req_addr (in, 31); req_len (in, 4).
REQ-007 The block SHALL have client write-data ports: wd_valid (in, 1); wd_ready (out, 1); wd_data (in, 64); wd_mask (in, 8).
REQ-008 The block SHALL have FSAB-side ports: out_valid (out, 1); out_mode (out, 1); out_did (out, 4); out_subdid (out, 4); out_addr (out, 31); out_len (out, 4); out_data (out, 64); out_mask (out, 8); out_credit (in, 1), one pulse per slot freed downstream.
REQ-009 The block SHALL have status ports: credits (out, 3), the current credit count; busy (out, 1); err_credit (out, 1), a sticky flag.

Function
REQ-010 The block SHALL hold credit_cnt, range 0..INITIAL_CREDITS.
- Decrements by 1 on each header issue.
- Increments by 1 on each out_credit pulse.
- Stays unchanged when an issue and an out_credit pulse occur in the same cycle.
REQ-011 The block SHALL NOT increment credit_cnt past INITIAL_CREDITS; an out_credit pulse at INITIAL_CREDITS with no simultaneous issue SHALL set err_credit, which stays set until rst.
REQ-012 The block SHALL implement an FSM with states IDLE and WBEATS.
REQ-013 In IDLE, req_ready SHALL be asserted combinationally when credit_cnt>0 and either req_mode==read or wd_valid==1.
REQ-014 In IDLE, wd_ready SHALL equal req_ready AND req_mode==write.
REQ-015 A header SHALL be accepted when req_valid && req_ready.
REQ-016 The accepted header SHALL appear on out_* in the next cycle with out_valid=1, because all out_* signals are registered (latency 1).
REQ-017 For an accepted read: out_data=0 and out_mask=0; exactly one beat is sent; the FSM stays in IDLE.
REQ-018 For an accepted write: beat 0 carries the header plus wd_data/wd_mask.
- eff_len = max(req_len, 1); req_len=0 is issued as 1 beat.
- If eff_len>1, the FSM moves to WBEATS with beats_rem = eff_len-1.
REQ-019 In WBEATS:
- wd_ready=1 and req_ready=0.
- Each wd_valid beat produces one out_valid beat in the next cycle; out_mode/did/subdid/addr/len hold the header values.
- beats_rem decrements on each beat; reaching 0 returns the FSM to IDLE.
REQ-020 In WBEATS, cycles with wd_valid=0 SHALL produce out_valid=0 (gaps allowed); no other output changes during a gap.
REQ-021 The block SHALL issue back-to-back headers: a new header may be accepted in the IDLE cycle directly after the last write beat, given a credit is available.
REQ-022 req_len values greater than LEN_MAX SHALL be clamped to LEN_MAX for both beat count and out_len.
REQ-023 busy SHALL be 1 when the FSM is in WBEATS or out_valid=1.
REQ-024 When out_valid=0, the out_* payload SHALL hold its last value; out_valid is the only qualifier.

Reset
REQ-025 On rst=1 at a clock edge, the block SHALL set: FSM=IDLE, credit_cnt=INITIAL_CREDITS, beats_rem=0, out_valid=0, all out_* payload=0, err_credit=0.
REQ-026 Asserting rst mid-write SHALL abandon the remaining beats with no further out_valid; out_credit is ignored while rst=1.
REQ-027 In the first cycle after rst deasserts, req_ready SHALL follow REQ-013 using credit_cnt=INITIAL_CREDITS.

Verification
REQ-028 Scenario — read burst without credit returns: 5 read requests, no out_credit -> 4 out_valid beats on cycles 1-4; req_ready=0 after that; credits=0. One out_credit pulse -> the 5th read issues one cycle later.
REQ-029 Scenario — write with gaps: write with req_len=4, wd_valid pattern 1,1,0,1,1 -> out_valid pattern 1,1,0,1,1 (latency 1); out_len=4 on every beat; FSM returns to IDLE after beat 4.
REQ-030 Scenario — simultaneous issue and credit: credits=1 plus an accepted read in the same cycle as out_credit -> credits stays 1.
REQ-031 Scenario — credit overflow: out_credit pulse while credits=4 -> err_credit=1 and credits=4; err_credit stays 1 until rst.
REQ-032 Scenario — reset mid-write: rst after beat 2 of a len-8 write -> out_valid=0 from the next cycle; credits=4; a new read is accepted in the first cycle after rst falls.
REQ-033 Scenario — zero/oversize lengths: write req_len=0 -> 1 beat and FSM stays IDLE; write req_len=12 -> 8 beats and out_len=8.

Source files
------------

// File: rtl/fsab_credit_issuer.sv
// Credit-gated request issuer for the FSAB: headers spend a credit from the
// downstream arbiter FIFO, and write bursts stream their data beats behind them.
module fsab_credit_issuer #(
  parameter int unsigned INITIAL_CREDITS = 4,
  parameter int unsigned LEN_MAX         = 8,
  parameter logic        WRITE_MODE      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mode,
  input  logic [3:0]  req_did,
  input  logic [3:0]  req_subdid,
  input  logic [30:0] req_addr,
  input  logic [3:0]  req_len,
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [63:0] wd_data,
  input  logic [7:0]  wd_mask,
  output logic        out_valid,
  output logic        out_mode,
  output logic [3:0]  out_did,
  output logic [3:0]  out_subdid,
  output logic [30:0] out_addr,
  output logic [3:0]  out_len,
  output logic [63:0] out_data,
  output logic [7:0]  out_mask,
  input  logic        out_credit,
  output logic [2:0]  credits,
  output logic        busy,
  output logic        err_credit
);

  typedef enum logic {IDLE, WBEATS} state_t;

  localparam logic [2:0] CREDITS_INIT = 3'(INITIAL_CREDITS);
  localparam logic [3:0] LEN_LIMIT    = 4'(LEN_MAX);
  localparam logic       READ_MODE    = ~WRITE_MODE;

  state_t      state_q, state_d;
  logic [2:0]  credit_cnt_q, credit_cnt_d;
  logic [3:0]  beats_rem_q, beats_rem_d;
  logic        err_credit_q, err_credit_d;
  logic        out_valid_q, out_valid_d;
  logic        out_mode_q, out_mode_d;
  logic [3:0]  out_did_q, out_did_d;
  logic [3:0]  out_subdid_q, out_subdid_d;
  logic [30:0] out_addr_q, out_addr_d;
  logic [3:0]  out_len_q, out_len_d;
  logic [63:0] out_data_q, out_data_d;
  logic [7:0]  out_mask_q, out_mask_d;

  logic [3:0]  len_clamped;
  logic [3:0]  eff_len;
  logic        hdr_issue;

  // Oversize lengths clamp for both out_len and beat count; zero still sends one beat.
  always_comb begin
    len_clamped = (req_len > LEN_LIMIT) ? LEN_LIMIT : req_len;
    eff_len     = (len_clamped == 4'd0) ? 4'd1 : len_clamped;
  end

  // A write header is only taken together with its first data beat.
  always_comb begin
    req_ready = 1'b0;
    wd_ready  = 1'b0;
    if (state_q == IDLE) begin
      req_ready = (credit_cnt_q != 3'd0) && ((req_mode == READ_MODE) || wd_valid);
      wd_ready  = req_ready && (req_mode == WRITE_MODE);
    end else begin
      wd_ready  = 1'b1;
    end
  end

  assign hdr_issue = req_valid && req_ready;

  // A returned credit that would exceed the FIFO depth is dropped and flagged.
  always_comb begin
    credit_cnt_d = credit_cnt_q;
    err_credit_d = err_credit_q;
    if (hdr_issue && !out_credit) begin
      credit_cnt_d = credit_cnt_q - 3'd1;
    end else if (out_credit && !hdr_issue) begin
      if (credit_cnt_q == CREDITS_INIT) begin
        err_credit_d = 1'b1;
      end else begin
        credit_cnt_d = credit_cnt_q + 3'd1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    beats_rem_d  = beats_rem_q;
    out_valid_d  = 1'b0;
    out_mode_d   = out_mode_q;
    out_did_d    = out_did_q;
    out_subdid_d = out_subdid_q;
    out_addr_d   = out_addr_q;
    out_len_d    = out_len_q;
    out_data_d   = out_data_q;
    out_mask_d   = out_mask_q;
    case (state_q)
      IDLE: begin
        if (hdr_issue) begin
          out_valid_d  = 1'b1;
          out_mode_d   = req_mode;
          out_did_d    = req_did;
          out_subdid_d = req_subdid;
          out_addr_d   = req_addr;
          out_len_d    = len_clamped;
          if (req_mode == WRITE_MODE) begin
            out_data_d = wd_data;
            out_mask_d = wd_mask;
            if (eff_len > 4'd1) begin
              state_d     = WBEATS;
              beats_rem_d = eff_len - 4'd1;
            end
          end else begin
            out_data_d = 64'd0;
            out_mask_d = 8'd0;
          end
        end
      end
      WBEATS: begin
        // Header fields stay latched; only data and mask advance per beat.
        if (wd_valid) begin
          out_valid_d = 1'b1;
          out_data_d  = wd_data;
          out_mask_d  = wd_mask;
          beats_rem_d = beats_rem_q - 4'd1;
          if (beats_rem_q == 4'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      credit_cnt_q <= CREDITS_INIT;
      beats_rem_q  <= 4'd0;
      err_credit_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_mode_q   <= 1'b0;
      out_did_q    <= 4'd0;
      out_subdid_q <= 4'd0;
      out_addr_q   <= 31'd0;
      out_len_q    <= 4'd0;
      out_data_q   <= 64'd0;
      out_mask_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      credit_cnt_q <= credit_cnt_d;
      beats_rem_q  <= beats_rem_d;
      err_credit_q <= err_credit_d;
      out_valid_q  <= out_valid_d;
      out_mode_q   <= out_mode_d;
      out_did_q    <= out_did_d;
      out_subdid_q <= out_subdid_d;
      out_addr_q   <= out_addr_d;
      out_len_q    <= out_len_d;
      out_data_q   <= out_data_d;
      out_mask_q   <= out_mask_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_mode   = out_mode_q;
  assign out_did    = out_did_q;
  assign out_subdid = out_subdid_q;
  assign out_addr   = out_addr_q;
  assign out_len    = out_len_q;
  assign out_data   = out_data_q;
  assign out_mask   = out_mask_q;
  assign credits    = credit_cnt_q;
  assign err_credit = err_credit_q;
  assign busy       = (state_q == WBEATS) || out_valid_q;

endmodule

// File: tb/tb_fsab_credit_issuer.sv
// Self-checking bench for fsab_credit_issuer: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_fsab_credit_issuer;

  localparam int INIT = 4;
  localparam int LMAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_mode, wd_valid, out_credit;
  logic [3:0]  req_did, req_subdid, req_len;
  logic [30:0] req_addr;
  logic [63:0] wd_data;
  logic [7:0]  wd_mask;
  logic        req_ready, wd_ready, out_valid, out_mode, busy, err_credit;
  logic [3:0]  out_did, out_subdid, out_len;
  logic [30:0] out_addr;
  logic [63:0] out_data;
  logic [7:0]  out_mask;
  logic [2:0]  credits;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fsab_credit_issuer #(.INITIAL_CREDITS(INIT), .LEN_MAX(LMAX), .WRITE_MODE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_did(req_did), .req_subdid(req_subdid), .req_addr(req_addr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_mask(wd_mask),
    .out_valid(out_valid), .out_mode(out_mode), .out_did(out_did), .out_subdid(out_subdid),
    .out_addr(out_addr), .out_len(out_len), .out_data(out_data), .out_mask(out_mask),
    .out_credit(out_credit), .credits(credits), .busy(busy), .err_credit(err_credit)
  );

  // Reference model: credit pool, remaining write beats, last emitted beat.
  int          m_credits;
  bit          m_err;
  int          m_left;
  logic        m_valid, m_mode;
  logic [3:0]  m_did, m_subdid, m_len;
  logic [30:0] m_addr;
  logic [63:0] m_data;
  logic [7:0]  m_mask;

  function automatic bit m_req_ready();
    return (m_left == 0) && (m_credits > 0) && (req_mode == 1'b0 || wd_valid == 1'b1);
  endfunction

  function automatic bit m_wd_ready();
    return (m_left > 0) || (m_req_ready() && req_mode == 1'b1);
  endfunction

  task automatic model_update();
    bit issue;
    bit beat;
    int clen;
    if (rst) begin
      m_credits = INIT; m_err = 0; m_left = 0; m_valid = 0;
      m_mode = 0; m_did = 0; m_subdid = 0; m_addr = 0; m_len = 0; m_data = 0; m_mask = 0;
    end else begin
      issue = req_valid && m_req_ready();
      beat  = (m_left > 0) && wd_valid;
      if (issue && !out_credit) m_credits--;
      else if (out_credit && !issue) begin
        if (m_credits == INIT) m_err = 1;
        else m_credits++;
      end
      m_valid = issue || beat;
      if (issue) begin
        clen = (req_len > LMAX) ? LMAX : int'(req_len);
        m_mode = req_mode; m_did = req_did; m_subdid = req_subdid; m_addr = req_addr;
        m_len = 4'(clen);
        m_data = req_mode ? wd_data : 64'd0;
        m_mask = req_mode ? wd_mask : 8'd0;
        m_left = req_mode ? ((clen < 1 ? 1 : clen) - 1) : 0;
      end else if (beat) begin
        m_data = wd_data; m_mask = wd_mask; m_left--;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; req_valid = 0; req_mode = 0; req_did = 0; req_subdid = 0; req_addr = 0;
    req_len = 0; wd_valid = 0; wd_data = 0; wd_mask = 0; out_credit = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; out_credit = 1; req_valid = 1; req_mode = 0;
    tick(); tick();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++; if (credits !== 3'd4) begin tests_failed++; $display("[TB] FAIL reset_credits: got %0d want 4", credits); end
    tests_run++; if (err_credit !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b want 0", err_credit); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if ({out_addr, out_data, out_len, out_mask} !== '0) begin tests_failed++; $display("[TB] FAIL reset_payload: got %h %h %h %h want 0", out_addr, out_data, out_len, out_mask); end
    idle_inputs();
    req_mode = 0; #1;
    tests_run++; if (req_ready !== 1'b1 || wd_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_reset_read_ready: got %b/%b want 1/0", req_ready, wd_ready); end
    req_mode = 1; wd_valid = 0; #1;
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL write_no_data_ready: got %b want 0", req_ready); end
    wd_valid = 1; #1;
    tests_run++; if (req_ready !== 1'b1 || wd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL write_data_ready: got %b/%b want 1/1", req_ready, wd_ready); end
    idle_inputs();
  endtask

  task automatic test_read_burst();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req_valid = 1; req_mode = 0; req_did = 4'(k); req_addr = 31'('h100 + k * 16); req_len = 4'd3;
      wd_valid = 1; wd_data = 64'hDEAD; wd_mask = 8'hFF;
      #1;
      tests_run++; if (req_ready !== (k < 4)) begin tests_failed++; $display("[TB] FAIL burst_ready_%0d: got %b want %b", k, req_ready, (k < 4)); end
      tick();
      tests_run++; if (out_valid !== (k < 4)) begin tests_failed++; $display("[TB] FAIL burst_valid_%0d: got %b want %b", k, out_valid, (k < 4)); end
      if (k == 0) begin
        tests_run++; if (out_data !== 64'd0 || out_mask !== 8'd0 || out_len !== 4'd3) begin tests_failed++; $display("[TB] FAIL burst_read_payload: got %h %h %0d want 0 0 3", out_data, out_mask, out_len); end
      end
    end
    tests_run++; if (credits !== 3'd0) begin tests_failed++; $display("[TB] FAIL burst_credits_empty: got %0d want 0", credits); end
    out_credit = 1; #1;
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL burst_ready_on_return: got %b want 0", req_ready); end
    tick();
    out_credit = 0;
    tests_run++; if (credits !== 3'd1 || out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL burst_credit_back: got %0d/%b want 1/0", credits, out_valid); end
    #1;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL burst_fifth_ready: got %b want 1", req_ready); end
    tick();
    tests_run++; if (out_valid !== 1'b1 || out_addr !== 31'h140 || credits !== 3'd0) begin tests_failed++; $display("[TB] FAIL burst_fifth_issue: got %b %h %0d want 1 140 0", out_valid, out_addr, credits); end
    idle_inputs();
  endtask

  task automatic test_write_gaps();
    bit pat [5] = '{1, 1, 0, 1, 1};
    logic [63:0] last;
    do_reset();
    req_valid = 1; req_mode = 1; req_len = 4; req_did = 4'h3; req_subdid = 4'h5; req_addr = 31'h1234;
    wd_valid = 1; wd_data = 64'hA5A5_0000_0000_0000; wd_mask = 8'h0F;
    last = wd_data;
    tick();
    tests_run++; if (out_valid !== 1'b1 || out_data !== last || out_len !== 4'd4 || out_mode !== 1'b1) begin tests_failed++; $display("[TB] FAIL gaps_beat0: got %b %h %0d %b want 1 %h 4 1", out_valid, out_data, out_len, out_mode, last); end
    req_valid = 0; req_mode = 0;
    for (int i = 1; i < 5; i++) begin
      wd_valid = pat[i]; wd_data = 64'hA5A5_0000_0000_0000 + 64'(i); wd_mask = 8'(i);
      if (pat[i]) last = wd_data;
      #1;
      tests_run++; if (req_ready !== 1'b0 || wd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL gaps_ready_%0d: got %b/%b want 0/1", i, req_ready, wd_ready); end
      tick();
      tests_run++; if (out_valid !== pat[i] || out_len !== 4'd4 || out_data !== last || out_addr !== 31'h1234) begin tests_failed++; $display("[TB] FAIL gaps_beat_%0d: got %b %0d %h %h want %b 4 %h 1234", i, out_valid, out_len, out_data, out_addr, pat[i], last); end
    end
    wd_valid = 0; #1;
    tests_run++; if (req_ready !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL gaps_idle_after: got %b/%b want 1/1", req_ready, busy); end
    tick();
    tests_run++; if (busy !== 1'b0 || out_valid !== 1'b0 || credits !== 3'd3) begin tests_failed++; $display("[TB] FAIL gaps_done: got %b %b %0d want 0 0 3", busy, out_valid, credits); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_valid = 1; req_mode = 1; req_len = 2; req_addr = 31'h10; wd_valid = 1; wd_data = 64'h1;
    tick();
    req_addr = 31'h20; wd_data = 64'h2;
    tick();
    tests_run++; if (out_valid !== 1'b1 || out_addr !== 31'h10 || out_data !== 64'h2) begin tests_failed++; $display("[TB] FAIL b2b_beat1: got %b %h %h want 1 10 2", out_valid, out_addr, out_data); end
    req_len = 1; wd_data = 64'h3; #1;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_ready: got %b want 1", req_ready); end
    tick();
    tests_run++; if (out_valid !== 1'b1 || out_addr !== 31'h20 || out_len !== 4'd1 || credits !== 3'd2) begin tests_failed++; $display("[TB] FAIL b2b_second: got %b %h %0d %0d want 1 20 1 2", out_valid, out_addr, out_len, credits); end
    idle_inputs();
  endtask

  task automatic test_simul_credit();
    do_reset();
    req_valid = 1; req_mode = 0;
    tick(); tick(); tick();
    tests_run++; if (credits !== 3'd1) begin tests_failed++; $display("[TB] FAIL simul_pre: got %0d want 1", credits); end
    out_credit = 1; req_addr = 31'h77;
    tick();
    tests_run++; if (credits !== 3'd1 || out_valid !== 1'b1 || out_addr !== 31'h77 || err_credit !== 1'b0) begin tests_failed++; $display("[TB] FAIL simul_hold: got %0d %b %h %b want 1 1 77 0", credits, out_valid, out_addr, err_credit); end
    idle_inputs();
  endtask

  task automatic test_overflow();
    do_reset();
    req_valid = 1; req_mode = 0; out_credit = 1;
    tick();
    tests_run++; if (credits !== 3'd4 || err_credit !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_issue_and_credit: got %0d %b want 4 0", credits, err_credit); end
    req_valid = 0;
    tick();
    out_credit = 0;
    tests_run++; if (credits !== 3'd4 || err_credit !== 1'b1) begin tests_failed++; $display("[TB] FAIL overflow_set: got %0d %b want 4 1", credits, err_credit); end
    req_valid = 1;
    tick();
    req_valid = 0;
    tick(); tick();
    tests_run++; if (err_credit !== 1'b1 || credits !== 3'd3) begin tests_failed++; $display("[TB] FAIL overflow_sticky: got %b %0d want 1 3", err_credit, credits); end
    do_reset();
    tests_run++; if (err_credit !== 1'b0) begin tests_failed++; $display("[TB] FAIL overflow_clear: got %b want 0", err_credit); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    req_valid = 1; req_mode = 1; req_len = 8; wd_valid = 1; wd_data = 64'hB0;
    tick();
    req_valid = 0; wd_data = 64'hB1;
    tick();
    rst = 1; out_credit = 1; wd_data = 64'hB2;
    tick();
    tests_run++; if (out_valid !== 1'b0 || credits !== 3'd4 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_state: got %b %0d %b want 0 4 0", out_valid, credits, busy); end
    rst = 0; out_credit = 0; req_valid = 1; req_mode = 0; req_addr = 31'h55; #1;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_ready: got %b want 1", req_ready); end
    tick();
    tests_run++; if (out_valid !== 1'b1 || out_mode !== 1'b0 || out_data !== 64'd0 || credits !== 3'd3 || err_credit !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_read: got %b %b %h %0d %b want 1 0 0 3 0", out_valid, out_mode, out_data, credits, err_credit); end
    req_valid = 0;
    tick();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_no_beats: got %b want 0", out_valid); end
    idle_inputs();
  endtask

  task automatic test_lengths();
    int beats;
    do_reset();
    req_valid = 1; req_mode = 1; req_len = 0; wd_valid = 1; wd_data = 64'hC0;
    tick();
    tests_run++; if (out_valid !== 1'b1 || out_len !== 4'd0) begin tests_failed++; $display("[TB] FAIL len0_beat: got %b %0d want 1 0", out_valid, out_len); end
    req_valid = 0; req_mode = 0; #1;
    tests_run++; if (req_ready !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL len0_idle: got %b %b want 1 1", req_ready, busy); end
    tick();
    req_valid = 1; req_mode = 1; req_len = 12;
    beats = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      req_valid = 0; req_mode = 0;
      if (out_valid) begin
        beats++;
        tests_run++; if (out_len !== 4'd8) begin tests_failed++; $display("[TB] FAIL len12_out_len: got %0d want 8", out_len); end
      end
    end
    tests_run++; if (beats != 8) begin tests_failed++; $display("[TB] FAIL len12_beats: got %0d want 8", beats); end
    #1;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL len12_idle: got %b want 1", req_ready); end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      req_valid  = 1'($urandom_range(0, 1));
      req_mode   = 1'($urandom_range(0, 1));
      req_did    = 4'($urandom);
      req_subdid = 4'($urandom);
      req_addr   = 31'($urandom);
      req_len    = 4'($urandom_range(0, 15));
      wd_valid   = ($urandom_range(0, 3) != 0);
      wd_data    = {$urandom, $urandom};
      wd_mask    = 8'($urandom);
      out_credit = (m_credits < INIT) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
      #1;
      if (!rst) begin
        tests_run++; if (req_ready !== m_req_ready() || wd_ready !== m_wd_ready()) begin tests_failed++; $display("[TB] FAIL rand_ready c=%0d: got %b/%b want %b/%b", c, req_ready, wd_ready, m_req_ready(), m_wd_ready()); end
      end
      tick();
      tests_run++;
      if (out_valid !== m_valid || credits !== 3'(m_credits) || err_credit !== m_err || busy !== ((m_left > 0) || m_valid)) begin
        tests_failed++;
        $display("[TB] FAIL rand_status c=%0d: got v%b cr%0d e%b b%b want v%b cr%0d e%b b%b", c, out_valid, credits, err_credit, busy, m_valid, m_credits, m_err, (m_left > 0) || m_valid);
      end
      tests_run++;
      if ({out_mode, out_did, out_subdid, out_addr, out_len, out_data, out_mask} !== {m_mode, m_did, m_subdid, m_addr, m_len, m_data, m_mask}) begin
        tests_failed++;
        $display("[TB] FAIL rand_payload c=%0d: got %b %h %h %h %0d %h %h want %b %h %h %h %0d %h %h", c, out_mode, out_did, out_subdid, out_addr, out_len, out_data, out_mask, m_mode, m_did, m_subdid, m_addr, m_len, m_data, m_mask);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_credits = INIT; m_err = 0; m_left = 0; m_valid = 0;
    test_reset();
    test_read_burst();
    test_write_gaps();
    test_back_to_back();
    test_simul_credit();
    test_overflow();
    test_reset_mid_write();
    test_lengths();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
